// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit owning HI/LO, sequencing fixed-latency MULT/DIV and MTxx/MFxx
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDU_op,
    input  logic        start,
    input  logic        flush,
    input  logic [31:0] MDU_opA,
    input  logic [31:0] MDU_opB,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDU_result
);
    localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d, wr_q, wr_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   hi_tmp_q, hi_tmp_d, lo_tmp_q, lo_tmp_d;
    logic          launch, is_div;
    logic [63:0]   prod_s, prod_u, res;
    logic [31:0]   a_mag, b_mag, mq, mr, q_s, r_s, q_u, r_u;

    assign is_div = MDU_op == 4'd3 || MDU_op == 4'd4;
    assign launch = state_q == IDLE && start && !flush && MDU_op >= 4'd1 && MDU_op <= 4'd4;

    // Signed product from sign-extended operands; the low 64 bits are exact
    assign prod_s = {{32{MDU_opA[31]}}, MDU_opA} * {{32{MDU_opB[31]}}, MDU_opB};
    assign prod_u = {32'b0, MDU_opA} * {32'b0, MDU_opB};

    // Signed divide via magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000
    assign a_mag = MDU_opA[31] ? -MDU_opA : MDU_opA;
    assign b_mag = MDU_opB[31] ? -MDU_opB : MDU_opB;
    assign mq    = b_mag == '0 ? '0 : a_mag / b_mag;
    assign mr    = b_mag == '0 ? '0 : a_mag % b_mag;
    assign q_s   = (MDU_opA[31] ^ MDU_opB[31]) ? -mq : mq;
    assign r_s   = MDU_opA[31] ? -mr : mr;
    assign q_u   = MDU_opB == '0 ? '0 : MDU_opA / MDU_opB;
    assign r_u   = MDU_opB == '0 ? '0 : MDU_opA % MDU_opB;

    assign res = MDU_op == 4'd1 ? prod_s :
                 MDU_op == 4'd2 ? prod_u :
                 MDU_op == 4'd3 ? {r_s, q_s} : {r_u, q_u};

    assign busy       = busy_q;
    assign HI         = hi_q;
    assign LO         = lo_q;
    assign MDU_result = MDU_op == 4'd7 ? hi_q : MDU_op == 4'd8 ? lo_q : '0;

    // Next state: count down in RUN and commit on the last cycle; launch or MTHI/MTLO in IDLE
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        wr_d     = wr_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        hi_tmp_d = hi_tmp_q;
        lo_tmp_d = lo_tmp_q;
        if (state_q == RUN) begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                state_d = IDLE;
                busy_d  = 1'b0;
                hi_d    = wr_q ? hi_tmp_q : hi_q;
                lo_d    = wr_q ? lo_tmp_q : lo_q;
            end
        end else if (launch) begin
            state_d              = RUN;
            busy_d               = 1'b1;
            cnt_d                = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            wr_d                 = !(is_div && MDU_opB == '0);
            {hi_tmp_d, lo_tmp_d} = res;
        end else if (!flush) begin
            hi_d = MDU_op == 4'd5 ? MDU_opA : hi_q;
            lo_d = MDU_op == 4'd6 ? MDU_opA : lo_q;
        end
    end

    // State and HI/LO registers; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            wr_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            hi_tmp_q <= '0;
            lo_tmp_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            wr_q     <= wr_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            hi_tmp_q <= hi_tmp_d;
            lo_tmp_q <= lo_tmp_d;
        end
    end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed and randomized checks of mdu_ctrl against a behavioural HI/LO model
module tb_mdu_ctrl;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, flush = 1'b0;
    logic [3:0]  op = '0;
    logic [31:0] a = '0, b = '0;
    logic        busy;
    logic [31:0] hi, lo, res;
    int          checks = 0, errors = 0;
    bit          cmp_en = 1'b0;

    mdu_ctrl dut (
        .clk(clk), .reset(reset), .MDU_op(op), .start(start), .flush(flush),
        .MDU_opA(a), .MDU_opB(b), .busy(busy), .HI(hi), .LO(lo), .MDU_result(res)
    );

    always #5 clk = ~clk;

    // Behavioural model: remaining busy cycles plus the pending 64-bit result
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    int          m_rem = 0;
    bit          p_wr = 1'b0;

    always @(posedge clk) begin : model
        longint sa, sb, ua, ub, q, rm;
        logic [63:0] r;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        ua = longint'(a);
        ub = longint'(b);
        r  = '0;
        if (reset) begin
            m_hi  = '0;
            m_lo  = '0;
            m_rem = 0;
        end else if (m_rem > 0) begin
            m_rem = m_rem - 1;
            if (m_rem == 0 && p_wr) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (start && !flush && op >= 1 && op <= 4) begin
            p_wr = 1'b1;
            if (op == 1) r = sa * sb;
            else if (op == 2) r = ua * ub;
            else if (b == 0) p_wr = 1'b0;
            else if (op == 3) begin
                q = sa / sb;
                rm = sa % sb;
                r = {rm[31:0], q[31:0]};
            end else begin
                q = ua / ub;
                rm = ua % ub;
                r = {rm[31:0], q[31:0]};
            end
            {p_hi, p_lo} = r;
            m_rem = (op >= 3) ? 10 : 5;
        end else if (!flush && op == 5) m_hi = a;
        else if (!flush && op == 6) m_lo = a;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", {31'b0, busy}, {31'b0, m_rem != 0});
            chk("HI", hi, m_hi);
            chk("LO", lo, m_lo);
            chk("MDU_result", res, op == 7 ? m_hi : op == 8 ? m_lo : 32'h0);
        end
    end

    task automatic drive(input logic [3:0] o, input logic s, input logic f,
                         input logic [31:0] x, input logic [31:0] y);
        op = o; start = s; flush = f; a = x; b = y;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(4'd0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            idle();
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    int n;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        cmp_en = 1'b1;
        reset = 1'b0;
        chk("reset busy", {31'b0, busy}, 32'h0);
        chk("reset HI", hi, 32'h0);
        chk("reset LO", lo, 32'h0);

        drive(4'd1, 1'b1, 1'b0, 32'hFFFFFFFE, 32'h3);
        wait_done(n);
        chk("MULT cycles", n, 5);
        chk("MULT HI", hi, 32'hFFFFFFFF);
        chk("MULT LO", lo, 32'hFFFFFFFA);

        drive(4'd2, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h2);
        wait_done(n);
        chk("MULTU cycles", n, 5);
        chk("MULTU HI", hi, 32'h1);
        chk("MULTU LO", lo, 32'hFFFFFFFE);

        drive(4'd3, 1'b1, 1'b0, 32'hFFFFFFF9, 32'h2);
        wait_done(n);
        chk("DIV cycles", n, 10);
        chk("DIV LO", lo, 32'hFFFFFFFD);
        chk("DIV HI", hi, 32'hFFFFFFFF);

        drive(4'd3, 1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF);
        wait_done(n);
        chk("DIV ovf LO", lo, 32'h80000000);
        chk("DIV ovf HI", hi, 32'h0);

        drive(4'd5, 1'b0, 1'b0, 32'h1234, 32'h0);
        drive(4'd6, 1'b0, 1'b0, 32'h5678, 32'h0);
        drive(4'd4, 1'b1, 1'b0, 32'h7, 32'h0);
        wait_done(n);
        chk("DIVU0 cycles", n, 10);
        chk("DIVU0 HI", hi, 32'h1234);
        chk("DIVU0 LO", lo, 32'h5678);
        drive(4'd7, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("MFHI", res, 32'h1234);

        drive(4'd3, 1'b1, 1'b1, 32'h100, 32'h3);
        chk("flush busy", {31'b0, busy}, 32'h0);
        chk("flush HI", hi, 32'h1234);
        chk("flush LO", lo, 32'h5678);

        drive(4'd1, 1'b1, 1'b0, 32'h2, 32'h3);
        drive(4'd6, 1'b0, 1'b0, 32'hAA, 32'h0);
        chk("MTLO busy LO", lo, 32'h5678);
        wait_done(n);
        chk("MULT rest cycles", n, 4);
        chk("MULT small HI", hi, 32'h0);
        chk("MULT small LO", lo, 32'h6);

        drive(4'd1, 1'b1, 1'b0, 32'h7, 32'h9);
        idle();
        idle();
        reset = 1'b1;
        idle();
        reset = 1'b0;
        chk("abort busy", {31'b0, busy}, 32'h0);
        chk("abort HI", hi, 32'h0);
        chk("abort LO", lo, 32'h0);
        repeat (8) idle();
        chk("abort late LO", lo, 32'h0);

        for (int i = 0; i < 4000; i++) begin
            logic [3:0] o;
            o = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(1, 8)) : 4'($urandom_range(0, 15));
            reset = ($urandom_range(0, 299) == 0);
            drive(o, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), pick(),
                  ($urandom_range(0, 7) == 0) ? 32'h0 : pick());
        end
        reset = 1'b0;
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
